// File: rtl/pc_sequencer.sv
// pc_sequencer
//
// Program-counter and fetch sequencer for the microcoded CPU. Each instruction
// is fetched from program memory, latched into `instruction`, and presented to
// the microinstruction decoder. The decoder is released (HOLD low) for exactly
// one EXEC cycle per instruction. During that cycle the next PC is computed
// for sequential flow, jumps, conditional jumps and call/return through a
// small return stack. Memory-access (MOM) instructions are stretched by
// MEM_WAIT extra held cycles.
//
// Program memory is read with one cycle of latency: imem_addr (= pc) is
// presented during FETCH, and imem_data is captured on the edge that ends
// FETCH.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset, overrides every state
//   imem_addr    program memory address, always equal to pc
//   imem_data    program memory read data
//   instruction  registered instruction word presented to the decoder
//   HOLD         1 = decoder must not update, 0 = the single EXEC cycle
//   flag_z       zero flag, only sampled at the end of EXEC
//   flag_p0      P0 flag, only sampled at the end of EXEC
//   flag_cy      carry flag, only sampled at the end of EXEC
//   pc           current program counter
//   stack_err    sticky return-stack overflow/underflow, cleared by rst only

module pc_sequencer #(
    parameter int unsigned        ADDR_W      = 11,
    parameter int unsigned        INSTR_W     = 22,
    parameter int unsigned        STACK_DEPTH = 4,
    parameter int unsigned        MEM_WAIT    = 1,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instruction,
    output logic               HOLD,
    input  logic               flag_z,
    input  logic               flag_p0,
    input  logic               flag_cy,
    output logic [ADDR_W-1:0]  pc,
    output logic               stack_err
);

    // Stack pointer counts 0..STACK_DEPTH, so it needs one bit above the index.
    localparam int unsigned IdxW = $clog2(STACK_DEPTH);
    localparam int unsigned SpW  = IdxW + 1;

    // The wait counter holds the number of MEMWAIT cycles still to go after
    // the current one.
    localparam int unsigned        WaitW    = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [WaitW-1:0]   WaitLoad = (MEM_WAIT != 0) ? WaitW'(MEM_WAIT - 1) : '0;

    localparam logic [INSTR_W-1:0] InstrNop = INSTR_W'(22'h3F0000);
    localparam logic [INSTR_W-1:0] InstrRet = INSTR_W'(22'h060000);

    // Opcode fields: jumps are decoded on [21:11], BSR and MOM on [21:10].
    localparam logic [10:0] OpJump = 11'b100_0000_0000;
    localparam logic [10:0] OpJze  = 11'b101_0000_0000;
    localparam logic [10:0] OpJp0  = 11'b110_0000_0000;
    localparam logic [10:0] OpJcy  = 11'b111_0000_0000;
    localparam logic [11:0] OpBsr  = 12'b0111_0000_0000;
    localparam logic [11:0] OpMomA = 12'b0100_0000_0000;
    localparam logic [11:0] OpMomB = 12'b0101_0000_0000;

    typedef enum logic [1:0] {
        StReset,
        StFetch,
        StExec,
        StMemWait
    } state_e;

    state_e             state;
    logic [SpW-1:0]     sp;
    logic [WaitW-1:0]   wait_cnt;
    logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];

    logic [10:0]        op11;
    logic [11:0]        op12;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  jump_target;
    logic [ADDR_W-1:0]  bsr_target;
    logic [ADDR_W-1:0]  stack_top;
    logic [SpW-1:0]     sp_dec;
    logic               stack_full;
    logic               stack_empty;

    logic [ADDR_W-1:0]  pc_next;
    logic               do_push;
    logic               do_pop;
    logic               err_set;
    logic               is_mom;

    assign imem_addr   = pc;

    assign op11        = instruction[21:11];
    assign op12        = instruction[21:10];
    assign pc_inc      = pc + ADDR_W'(1);
    assign jump_target = ADDR_W'(instruction[10:0]);
    assign bsr_target  = ADDR_W'(instruction[9:0]);
    assign sp_dec      = sp - SpW'(1);
    assign stack_top   = stack_mem[sp_dec[IdxW-1:0]];
    assign stack_full  = (sp == SpW'(STACK_DEPTH));
    assign stack_empty = (sp == '0);

    // Next-PC decode. Only consumed on the edge that ends EXEC, so the flags
    // have no effect at any other time.
    always_comb begin
        pc_next = pc_inc;
        do_push = 1'b0;
        do_pop  = 1'b0;
        err_set = 1'b0;
        is_mom  = 1'b0;

        if (op11 == OpJump) begin
            pc_next = jump_target;
        end else if (op11 == OpJze) begin
            if (flag_z) begin
                pc_next = jump_target;
            end
        end else if (op11 == OpJp0) begin
            if (flag_p0) begin
                pc_next = jump_target;
            end
        end else if (op11 == OpJcy) begin
            if (flag_cy) begin
                pc_next = jump_target;
            end
        end else if (op12 == OpBsr) begin
            // Overflow drops the return address but the call still happens.
            pc_next = bsr_target;
            if (stack_full) begin
                err_set = 1'b1;
            end else begin
                do_push = 1'b1;
            end
        end else if (instruction == InstrRet) begin
            // Underflow falls through to the next instruction.
            if (stack_empty) begin
                err_set = 1'b1;
            end else begin
                do_pop  = 1'b1;
                pc_next = stack_top;
            end
        end else if ((op12 == OpMomA) || (op12 == OpMomB)) begin
            is_mom = 1'b1;
        end
    end

    // Sequencer FSM. HOLD is registered from the state being entered so it
    // is glitch-free and low only while the EXEC state is current.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StReset;
            pc          <= RESET_PC;
            sp          <= '0;
            stack_err   <= 1'b0;
            HOLD        <= 1'b1;
            instruction <= InstrNop;
            wait_cnt    <= '0;
        end else begin
            unique case (state)
                StReset: begin
                    state <= StFetch;
                    HOLD  <= 1'b1;
                end

                StFetch: begin
                    instruction <= imem_data;
                    state       <= StExec;
                    HOLD        <= 1'b0;
                end

                StExec: begin
                    pc   <= pc_next;
                    HOLD <= 1'b1;
                    if (do_push) begin
                        stack_mem[sp[IdxW-1:0]] <= pc_inc;
                        sp                      <= sp + SpW'(1);
                    end
                    if (do_pop) begin
                        sp <= sp_dec;
                    end
                    if (err_set) begin
                        stack_err <= 1'b1;
                    end
                    if (is_mom && (MEM_WAIT != 0)) begin
                        state    <= StMemWait;
                        wait_cnt <= WaitLoad;
                    end else begin
                        state <= StFetch;
                    end
                end

                StMemWait: begin
                    HOLD <= 1'b1;
                    if (wait_cnt == '0) begin
                        state <= StFetch;
                    end else begin
                        wait_cnt <= wait_cnt - WaitW'(1);
                    end
                end

                default: begin
                    state <= StReset;
                    HOLD  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer. An instruction-level reference model
// tracks pc, the latched instruction, the position inside the current
// instruction period and a return-stack queue; every cycle the DUT outputs
// are compared against it. Directed scenarios add hand-computed literal
// checks at fixed cycle offsets after reset.

module tb_pc_sequencer;

    localparam int unsigned AW    = 11;
    localparam int unsigned IW    = 22;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MW    = 2;
    localparam int          PcMod = 2048;

    localparam logic [IW-1:0] NOP = 22'h3F0000;
    localparam logic [IW-1:0] RET = 22'h060000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flag_z = 1'b0;
    logic          flag_p0 = 1'b0;
    logic          flag_cy = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_data;
    logic [IW-1:0] instruction;
    logic          hold;
    logic [AW-1:0] pc;
    logic          stack_err;

    logic [IW-1:0] mem [PcMod];

    int n_cmp = 0;
    int n_bad = 0;

    pc_sequencer #(
        .ADDR_W      (AW),
        .INSTR_W     (IW),
        .STACK_DEPTH (DEPTH),
        .MEM_WAIT    (MW),
        .RESET_PC    (11'h000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instruction (instruction),
        .HOLD        (hold),
        .flag_z      (flag_z),
        .flag_p0     (flag_p0),
        .flag_cy     (flag_cy),
        .pc          (pc),
        .stack_err   (stack_err)
    );

    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_slot: 0 = fetch cycle, 1 = execute cycle, 2.. = extra wait cycles.
    bit          m_on   = 1'b0;
    bit          m_boot = 1'b0;
    int          m_pc   = 0;
    logic [IW-1:0] m_ins = NOP;
    bit          m_err  = 1'b0;
    int          m_slot = 0;
    int          m_len  = 2;
    int          m_stk[$];

    always @(posedge clk) begin
        int nxt;
        if (rst) begin
            m_on   = 1'b1;
            m_boot = 1'b1;
            m_pc   = 0;
            m_ins  = NOP;
            m_err  = 1'b0;
            m_slot = 0;
            m_len  = 2;
            m_stk.delete();
        end else if (m_on) begin
            if (m_boot) begin
                m_boot = 1'b0;
                m_slot = 0;
            end else if (m_slot == 0) begin
                m_ins  = mem[m_pc];
                m_slot = 1;
            end else if (m_slot == 1) begin
                nxt   = (m_pc + 1) % PcMod;
                m_len = 2;
                if (m_ins[21:11] == 11'h400) begin
                    nxt = int'(m_ins[10:0]);
                end else if (m_ins[21:11] == 11'h500) begin
                    if (flag_z) nxt = int'(m_ins[10:0]);
                end else if (m_ins[21:11] == 11'h600) begin
                    if (flag_p0) nxt = int'(m_ins[10:0]);
                end else if (m_ins[21:11] == 11'h700) begin
                    if (flag_cy) nxt = int'(m_ins[10:0]);
                end else if (m_ins[21:10] == 12'h700) begin
                    if (m_stk.size() == DEPTH) m_err = 1'b1;
                    else m_stk.push_back(nxt);
                    nxt = int'(m_ins[9:0]);
                end else if (m_ins == RET) begin
                    if (m_stk.size() == 0) m_err = 1'b1;
                    else nxt = m_stk.pop_back();
                end else if (m_ins[21:10] == 12'h400 || m_ins[21:10] == 12'h500) begin
                    m_len = 2 + MW;
                end
                m_pc   = nxt;
                m_slot = (m_len > 2) ? 2 : 0;
            end else begin
                m_slot++;
                if (m_slot == m_len) m_slot = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("model.pc", pc, m_pc);
            chk("model.imem_addr", imem_addr, m_pc);
            chk("model.hold", hold, (m_slot == 1 && !m_boot) ? 1'b0 : 1'b1);
            chk("model.instruction", instruction, m_ins);
            chk("model.stack_err", stack_err, m_err);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_nops();
        for (int i = 0; i < PcMod; i++) mem[i] = NOP;
    endtask

    // Returns at the negedge of the post-reset cycle (still in the reset state).
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic lit(input string name, input int exp_pc, input logic exp_hold,
                       input logic exp_err);
        chk({name, ".pc"}, pc, exp_pc);
        chk({name, ".hold"}, hold, exp_hold);
        chk({name, ".err"}, stack_err, exp_err);
    endtask

    initial begin
        load_nops();

        // Reset followed by a NOP stream.
        do_reset();
        lit("reset", 0, 1'b1, 1'b0);
        chk("reset.instr", instruction, NOP);
        for (int i = 0; i < 6; i++) begin
            step(1);
            lit($sformatf("nop%0d", i), i / 2, (i % 2 == 0), 1'b0);
            chk($sformatf("nop%0d.instr", i), instruction, NOP);
        end

        // JUMP 0x155 at address 0.
        mem[0] = 22'h200155;
        do_reset();
        step(2);
        lit("jump.exec", 0, 1'b0, 1'b0);
        chk("jump.instr", instruction, 22'h200155);
        step(1);
        lit("jump.target", 'h155, 1'b1, 1'b0);

        // JZE 0x020, flag clear then set.
        mem[0] = 22'h280020;
        flag_z = 1'b0;
        do_reset();
        step(3);
        lit("jze.nottaken", 1, 1'b1, 1'b0);
        flag_z = 1'b1;
        do_reset();
        step(3);
        lit("jze.taken", 'h020, 1'b1, 1'b0);
        flag_z = 1'b0;

        // JP0 0x0AA, flag set.
        mem[0] = 22'h3000AA;
        flag_p0 = 1'b1;
        do_reset();
        step(3);
        lit("jp0.taken", 'h0AA, 1'b1, 1'b0);
        flag_p0 = 1'b0;

        // JCY: flag is high only during FETCH, then low in EXEC -> not taken.
        mem[0] = 22'h380020;
        do_reset();
        step(1);
        flag_cy = 1'b1;
        step(1);
        flag_cy = 1'b0;
        step(1);
        lit("jcy.fetchonly", 1, 1'b1, 1'b0);
        // And the reverse: low in FETCH, high in EXEC -> taken.
        do_reset();
        step(2);
        flag_cy = 1'b1;
        step(1);
        flag_cy = 1'b0;
        lit("jcy.execonly", 'h020, 1'b1, 1'b0);

        // BSR 0x100 at 5, RET at 0x100.
        load_nops();
        mem[5]     = 22'h1C0100;
        mem['h100] = RET;
        do_reset();
        step(13);
        lit("bsr.target", 'h100, 1'b1, 1'b0);
        step(2);
        lit("ret.back", 6, 1'b1, 1'b0);

        // Five nested calls overflow a four-entry stack on the fifth.
        load_nops();
        mem[0]    = 22'h1C0010;
        mem['h10] = 22'h1C0020;
        mem['h20] = 22'h1C0030;
        mem['h30] = 22'h1C0040;
        mem['h40] = 22'h1C0050;
        mem['h50] = RET;
        do_reset();
        step(9);
        lit("nest.before5", 'h040, 1'b1, 1'b0);
        step(2);
        lit("nest.after5", 'h050, 1'b1, 1'b1);
        step(2);
        lit("nest.ret", 'h031, 1'b1, 1'b1);

        // RET on an empty stack at 9.
        load_nops();
        mem[9] = RET;
        do_reset();
        step(21);
        lit("under.ret", 10, 1'b1, 1'b1);
        step(4);
        lit("under.sticky", 12, 1'b1, 1'b1);
        do_reset();
        lit("under.cleared", 0, 1'b1, 1'b0);

        // MOM at 3 and 4 (both encodings), MEM_WAIT = 2.
        load_nops();
        mem[3] = 22'h100123;
        mem[4] = 22'h140000;
        do_reset();
        step(8);
        lit("mom.exec", 3, 1'b0, 1'b0);
        step(1);
        lit("mom.wait1", 4, 1'b1, 1'b0);
        chk("mom.wait1.instr", instruction, 22'h100123);
        step(1);
        lit("mom.wait2", 4, 1'b1, 1'b0);
        chk("mom.wait2.instr", instruction, 22'h100123);
        step(1);
        lit("mom.fetch4", 4, 1'b1, 1'b0);
        step(1);
        lit("mom.exec4", 4, 1'b0, 1'b0);
        step(3);
        lit("mom.fetch5", 5, 1'b1, 1'b0);

        // Reset during the second MEMWAIT cycle.
        do_reset();
        step(10);
        lit("momrst.wait2", 4, 1'b1, 1'b0);
        rst = 1'b1;
        step(1);
        lit("momrst.reset", 0, 1'b1, 1'b0);
        chk("momrst.instr", instruction, NOP);
        rst = 1'b0;

        // Wrap from 0x7FF to 0 with a sticky error already set.
        load_nops();
        mem[0] = RET;
        mem[1] = 22'h2007FF;
        do_reset();
        step(5);
        lit("wrap.at7ff", 'h7FF, 1'b1, 1'b1);
        step(2);
        lit("wrap.zero", 0, 1'b1, 1'b1);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and fetch sequencer for the microcoded CPU. It fetches 22-bit instructions from program memory and presents each one, held stable, to the microinstruction decoder. It drives the decoder's HOLD input and computes the next PC for jumps, conditional jumps, and subroutine call/return through a small return stack. It also stretches memory-access instructions by a programmable number of wait cycles.

## Interface
Parameters:
- ADDR_W, 11, program address width (matches DATA_ADDR width)
- INSTR_W, 22, instruction width
- STACK_DEPTH, 4, return-stack entries (power of two, ≥2)
- MEM_WAIT, 1, extra cycles held for MOM instructions (≥0)
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- imem_addr  out  ADDR_W  program memory address (= pc)
- imem_data  in  INSTR_W  program memory data, valid one cycle after imem_addr
- instruction  out  INSTR_W  registered instruction to decoder
- HOLD  out  1  1 = decoder must not update; 0 = exactly one EXEC cycle
- flag_z  in  1  zero flag, sampled in EXEC
- flag_p0  in  1  P0 flag, sampled in EXEC
- flag_cy  in  1  carry flag, sampled in EXEC
- pc  out  ADDR_W  current program counter
- stack_err  out  1  sticky stack overflow/underflow

## Operation
States: RESET, FETCH, EXEC, MEMWAIT.
- RESET: entered while rst=1.
  - pc=RESET_PC, sp=0, stack_err=0, HOLD=1.
  - instruction = NOP (22'h3F0000).
  - Next state: FETCH.
- FETCH:
  - imem_addr=pc, HOLD=1.
  - On the clock edge, instruction ← imem_data.
  - Next state: EXEC.
- EXEC:
  - HOLD=0.
  - Decode on instruction; update pc on the edge.
  - Next state: MEMWAIT if MOM and MEM_WAIT>0, else FETCH.
- MEMWAIT:
  - HOLD=1; counts MEM_WAIT cycles.
  - Then FETCH. pc already updated to pc+1.

Decode (pc+1 wraps modulo 2^ADDR_W):
- [21:11]=10000000000 JUMP: pc ← [10:0].
- [21:11]=10100000000 JZE: pc ← [10:0] if flag_z, else pc+1.
- [21:11]=11000000000 JP0: pc ← [10:0] if flag_p0, else pc+1.
- [21:11]=11100000000 JCY: pc ← [10:0] if flag_cy, else pc+1.
- [21:10]=011100000000 BSR: push pc+1, then pc ← zero-extended [9:0].
  - If the stack is full: no push, stack_err←1, jump still taken.
- instruction=22'h060000 RET: pc ← pop.
  - If the stack is empty: pc ← pc+1, stack_err←1.
- [21:10]=010000000000 or 010100000000 (MOM): pc ← pc+1, plus the MEMWAIT stretch.
- All other encodings, NOP included: pc ← pc+1.
- Flags are sampled only in the EXEC cycle.
- stack_err clears only on rst.
- Return stack is a LIFO of STACK_DEPTH×ADDR_W, with sp in 0..STACK_DEPTH.

## Timing
- Non-MOM instruction: 2 cycles (FETCH+EXEC). MOM: 2+MEM_WAIT cycles.
- HOLD is low for exactly one cycle per instruction, and only in EXEC.
- instruction is stable from the end of FETCH through the end of EXEC/MEMWAIT.
- The decoder samples on negedge during EXEC; instruction never changes in the EXEC cycle.
- imem_addr equals pc at all times. Memory read latency is exactly 1 cycle.
- rst is sampled every edge and overrides every state, including mid-MEMWAIT.
  - The next cycle shows the RESET values.
  - Any pending push/pop is discarded.
- Reset values of all outputs:
  - imem_addr=pc=RESET_PC, instruction=22'h3F0000, HOLD=1, stack_err=0.
- pc wrap: pc=2^ADDR_W−1 with a non-jump instruction → pc=0 and no error.
- Conditional-jump flags change during FETCH with no effect; only the EXEC value counts.

## Test plan
- Reset then NOP stream:
  - rst for 2 cycles; program of NOPs at 0..3.
  - Required: pc sequence 0,0,1,1,2,2,… (FETCH/EXEC pairs).
  - Required: HOLD low on alternate cycles; instruction=22'h3F0000 throughout.
- Jumps:
  - JUMP 0x155 at addr 0 → pc=0x155 after EXEC.
  - JZE 0x020 with flag_z=0 → pc=1; same with flag_z=1 → pc=0x020.
  - JCY 0x020 with flag_cy toggled only during FETCH has no effect.
- Subroutine:
  - BSR 0x100 at addr 5; RET at 0x100.
  - Required: pc=0x100, then 6. stack_err=0.
  - 5 nested BSR with STACK_DEPTH=4 → stack_err=1 on the 5th; that jump still taken.
- RET underflow: RET with empty stack at addr 9 → pc=10, stack_err=1, held until rst.
- MOM stretch:
  - MEM_WAIT=2; MOM at addr 3.
  - Required: HOLD low exactly 1 cycle; instruction period 4 cycles; next pc=4.
  - rst asserted in the 2nd MEMWAIT cycle → next cycle pc=RESET_PC, HOLD=1.
- Wrap: pc=0x7FF holding NOP → next pc=0x000, stack_err unchanged.
